traffic_phase_scheduler: RTL

- Sequencing controller for a two-road signalised junction with a pedestrian crossing, packaged as a TinyTapeout user module (8-bit io_in / io_out).
- Owns the phase state machine, the per-phase dwell timer, a clock prescaler and the pedestrian-request latch.
- Drives the lamp outputs directly.
- Replaces ad-hoc two-flop light logic with a parameterised, timed scheduler.

---
 rtl/traffic_phase_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/traffic_phase_scheduler.sv
// Phase sequencer for a two-road junction with a pedestrian crossing.
// The dwell timer, prescaler and request latch all live here, and the lamps are decoded from the registered phase.
module traffic_phase_scheduler #(
    parameter int ALLRED_TICKS = 1,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 2,
    parameter int WALK_TICKS   = 4,
    parameter int TIMER_W      = 4
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [2:0] {
        S_ALLRED_A,
        S_A_GREEN,
        S_A_YELLOW,
        S_ALLRED_B,
        S_B_GREEN,
        S_B_YELLOW,
        S_WALK,
        S_FLASH
    } state_t;

    localparam logic [TIMER_W-1:0] T_ALLRED = TIMER_W'(ALLRED_TICKS - 1);
    localparam logic [TIMER_W-1:0] T_GREEN  = TIMER_W'(GREEN_TICKS - 1);
    localparam logic [TIMER_W-1:0] T_YELLOW = TIMER_W'(YELLOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] T_WALK   = TIMER_W'(WALK_TICKS - 1);

    logic       clk;
    logic       rst;
    logic       ped_req;
    logic       flash;
    logic       car_b;
    logic [1:0] sel;
    logic       unused_io;

    assign clk       = io_in[0];
    assign rst       = io_in[1];
    assign ped_req   = io_in[2];
    assign flash     = io_in[3];
    assign car_b     = io_in[4];
    assign unused_io = io_in[5];
    assign sel       = io_in[7:6];

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [2:0]           presc_q;
    logic                 pend_q, pend_d;
    logic                 flash_ph_q, flash_ph_d;
    logic [2:0]           presc_mask;
    logic                 tick;
    state_t               nxt;

    // Timer reload value is the phase dwell minus one, so a phase spans exactly N ticks.
    function automatic logic [TIMER_W-1:0] dwell_of(input state_t s);
        case (s)
            S_A_GREEN, S_B_GREEN:   dwell_of = T_GREEN;
            S_A_YELLOW, S_B_YELLOW: dwell_of = T_YELLOW;
            S_WALK:                 dwell_of = T_WALK;
            default:                dwell_of = T_ALLRED;
        endcase
    endfunction

    always_comb begin
        case (sel)
            2'd0:    presc_mask = 3'b000;
            2'd1:    presc_mask = 3'b001;
            2'd2:    presc_mask = 3'b011;
            default: presc_mask = 3'b111;
        endcase
    end

    assign tick = ((presc_q & presc_mask) == 3'b000);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pend_d     = pend_q;
        flash_ph_d = flash_ph_q;
        nxt        = state_q;

        if (state_q == S_FLASH) begin
            if (tick) begin
                flash_ph_d = ~flash_ph_q;
                if (!flash) begin
                    state_d = S_ALLRED_A;
                    timer_d = T_ALLRED;
                end
            end
        end else if (tick) begin
            if (timer_q != '0) begin
                timer_d = timer_q - TIMER_W'(1);
            end else begin
                case (state_q)
                    S_ALLRED_A: nxt = S_A_GREEN;
                    S_A_GREEN:  nxt = (car_b || pend_q) ? S_A_YELLOW : S_A_GREEN;
                    S_A_YELLOW: nxt = S_ALLRED_B;
                    S_ALLRED_B: nxt = S_B_GREEN;
                    S_B_GREEN:  nxt = S_B_YELLOW;
                    S_B_YELLOW: nxt = pend_q ? S_WALK : S_ALLRED_A;
                    default:    nxt = S_ALLRED_A;
                endcase
                if (flash) begin
                    state_d = S_FLASH;
                    timer_d = '0;
                end else begin
                    state_d = nxt;
                    timer_d = dwell_of(nxt);
                end
            end
        end

        // Entering WALK serves the request; that clear wins over a same-edge set.
        if (state_d == S_WALK && state_q != S_WALK) begin
            pend_d = 1'b0;
        end else if (ped_req && state_q != S_WALK) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_ALLRED_A;
            timer_q    <= T_ALLRED;
            presc_q    <= 3'd0;
            pend_q     <= 1'b0;
            flash_ph_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            presc_q    <= presc_q + 3'd1;
            pend_q     <= pend_d;
            flash_ph_q <= flash_ph_d;
        end
    end

    always_comb begin
        io_out = 8'h00;
        case (state_q)
            S_ALLRED_A, S_ALLRED_B: io_out[6:0] = 7'h09;
            S_A_GREEN:              io_out[6:0] = 7'h0C;
            S_A_YELLOW:             io_out[6:0] = 7'h0A;
            S_B_GREEN:              io_out[6:0] = 7'h21;
            S_B_YELLOW:             io_out[6:0] = 7'h11;
            S_WALK:                 io_out[6:0] = 7'h49;
            default:                io_out[6:0] = flash_ph_q ? 7'h0A : 7'h00;
        endcase
        io_out[7] = pend_q;
    end

endmodule
